// File: rtl/sec_ded_pkg.sv
// rtl/sec_ded_pkg.sv - shared SEC-DED code geometry helpers and syndrome classes
package sec_ded_pkg;

  typedef enum logic [2:0] {CLEAN, CE_PAR, CE_CHK, CE_DATA, UE} syn_class_e;

  function automatic int pw_of(input int dw);
    return $clog2(1 + dw + $clog2(1 + dw)) + 1;
  endfunction

  // Data bits skip the power-of-two slots reserved for Hamming check bits.
  function automatic int data_pos(input int i);
    return (i + 1) + $clog2(1 + (i + 1) + $clog2(1 + (i + 1)));
  endfunction

  function automatic logic is_pow2(input int s);
    return (s != 0) && ((s & (s - 1)) == 0);
  endfunction

endpackage

// File: rtl/hasioCoder.sv
// rtl/hasioCoder.sv - SEC-DED check-bit encoder: PW-1 Hamming bits plus overall parity msb
module hasioCoder
  import sec_ded_pkg::*;
#(
  parameter int DW = 32,
  parameter int PW = pw_of(DW)
) (
  input  logic [DW-1:0] data,
  output logic [PW-1:0] check
);

  logic [PW-2:0] ham;

  always_comb begin
    ham = '0;
    for (int j = 0; j < PW - 1; j++) begin
      for (int i = 0; i < DW; i++) begin
        if (((data_pos(i) >> j) & 1) != 0) ham[j] = ham[j] ^ data[i];
      end
    end
  end

  assign check = {(^data) ^ (^ham), ham};

endmodule

// File: rtl/sec_ded_decoder.sv
// rtl/sec_ded_decoder.sv - two-stage SEC-DED decoder with error counters and sticky irq
module sec_ded_decoder
  import sec_ded_pkg::*;
#(
  parameter int DW = 32,
  parameter int PW = pw_of(DW),
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [PW-1:0] in_check,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_ce,
  output logic          out_ue,
  output logic [PW-1:0] out_syndrome,
  output logic [CW-1:0] ce_count,
  output logic [CW-1:0] ue_count,
  input  logic          cnt_clr,
  output logic          err_irq
);

  localparam int SW = PW - 1;

  logic          s1_valid, s1_load, s2_load, out_fire;
  logic [DW-1:0] s1_data;
  logic [PW-1:0] s1_syn;
  logic [SW-1:0] rcheck_h;
  logic          unused_par;

  hasioCoder #(.DW(DW), .PW(PW)) u_coder (
    .data  (in_data),
    .check ({unused_par, rcheck_h})
  );

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_syn  <= {(^in_data) ^ (^in_check), rcheck_h ^ in_check[SW-1:0]};
      end
    end
  end

  logic [SW-1:0] syn_s;
  logic          syn_p, hit;
  logic [DW-1:0] corr;
  syn_class_e    cls;

  assign syn_s = s1_syn[SW-1:0];
  assign syn_p = s1_syn[PW-1];

  // Data is only flipped for CE_DATA; a double error whose s aliases a data position stays raw.
  always_comb begin
    corr = s1_data;
    hit  = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (syn_s == SW'(data_pos(i))) begin
        corr[i] = ~s1_data[i];
        hit     = 1'b1;
      end
    end
    cls = CLEAN;
    if (!syn_p)                   cls = (syn_s == '0) ? CLEAN : UE;
    else if (syn_s == '0)         cls = CE_PAR;
    else if (is_pow2(int'(syn_s))) cls = CE_CHK;
    else if (hit)                 cls = CE_DATA;
    else                          cls = UE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ce       <= 1'b0;
      out_ue       <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= (cls == CE_DATA) ? corr : s1_data;
        out_ce       <= (cls == CE_PAR) || (cls == CE_CHK) || (cls == CE_DATA);
        out_ue       <= (cls == UE);
        out_syndrome <= s1_syn;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_count <= '0;
      ue_count <= '0;
      err_irq  <= 1'b0;
    end else if (cnt_clr) begin
      ce_count <= '0;
      ue_count <= '0;
      err_irq  <= 1'b0;
    end else if (out_fire) begin
      if (out_ce && (ce_count != {CW{1'b1}})) ce_count <= ce_count + 1'b1;
      if (out_ue && (ue_count != {CW{1'b1}})) ue_count <= ue_count + 1'b1;
      if (out_ue) err_irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sec_ded_decoder.sv
// tb/tb_sec_ded_decoder.sv - directed self-checking bench for sec_ded_decoder
module tb_sec_ded_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [6:0]  in_check = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_ce, out_ue;
  logic [6:0]  out_syndrome;
  logic [15:0] ce_count, ue_count;
  logic        cnt_clr = 1'b0;
  logic        err_irq;

  int checks = 0;
  int errors = 0;

  sec_ded_decoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_check(in_check),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ce(out_ce), .out_ue(out_ue), .out_syndrome(out_syndrome),
    .ce_count(ce_count), .ue_count(ue_count), .cnt_clr(cnt_clr), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  task automatic run_word(input string name, input logic [31:0] d, input logic [6:0] c,
                          input logic [31:0] ed, input logic ece, input logic eue, input logic [6:0] esyn);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_check = c; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got %b exp 1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL %s latency got %0d exp 2", name, lat); end
    checks++;
    if (out_data !== ed) begin errors++; $display("FAIL %s out_data got %h exp %h", name, out_data, ed); end
    checks++;
    if (out_ce !== ece || out_ue !== eue)
      begin errors++; $display("FAIL %s ce/ue got %b/%b exp %b/%b", name, out_ce, out_ue, ece, eue); end
    checks++;
    if (out_syndrome !== esyn) begin errors++; $display("FAIL %s syndrome got %h exp %h", name, out_syndrome, esyn); end
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input string name, input logic [15:0] ec, input logic [15:0] eu, input logic ei);
    checks++;
    if (ce_count !== ec || ue_count !== eu || err_irq !== ei)
      begin errors++; $display("FAIL %s counters got ce=%0d ue=%0d irq=%b exp ce=%0d ue=%0d irq=%b",
                               name, ce_count, ue_count, err_irq, ec, eu, ei); end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ce !== 1'b0 || out_ue !== 1'b0 || out_syndrome !== '0)
      begin errors++; $display("FAIL reset outputs got v=%b d=%h ce=%b ue=%b syn=%h exp zeros",
                               out_valid, out_data, out_ce, out_ue, out_syndrome); end
    check_counts("reset", 16'd0, 16'd0, 1'b0);
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_clean;
    run_word("clean_zero", 32'h0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00);
    check_counts("clean_zero", 16'd0, 16'd0, 1'b0);
  endtask

  task automatic test_single_data;
    run_word("flip_d0", 32'h0, 7'h43, 32'h1, 1'b1, 1'b0, 7'h43);
    check_counts("flip_d0", 16'd1, 16'd0, 1'b0);
  endtask

  task automatic test_check_bits;
    run_word("flip_c2", 32'h0, 7'h04, 32'h0, 1'b1, 1'b0, 7'h44);
    run_word("flip_c6", 32'h0, 7'h40, 32'h0, 1'b1, 1'b0, 7'h40);
    check_counts("check_bits", 16'd3, 16'd0, 1'b0);
  endtask

  task automatic test_double;
    run_word("double", 32'h3, 7'h00, 32'h3, 1'b0, 1'b1, 7'h06);
    check_counts("double", 16'd3, 16'd1, 1'b1);
  endtask

  task automatic test_triple_and_clear;
    run_word("triple", 32'hE000_0000, 7'h00, 32'hE000_0000, 1'b0, 1'b1, 7'h67);
    check_counts("triple", 16'd3, 16'd2, 1'b1);
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    check_counts("cnt_clr", 16'd0, 16'd0, 1'b0);
  endtask

  task automatic test_high_bit;
    run_word("clean_hi", 32'hE000_0000, 7'h67, 32'hE000_0000, 1'b0, 1'b0, 7'h00);
    run_word("flip_d31", 32'h6000_0000, 7'h67, 32'hE000_0000, 1'b1, 1'b0, 7'h66);
    check_counts("flip_d31", 16'd1, 16'd0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] sd [8];
    logic [6:0]  sc [8];
    logic [31:0] prev_data;
    logic        prev_stall;
    int sent, rcvd, cyc;
    sd = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h8, 32'h3, 32'h6000_0000, 32'hE000_0000};
    sc = '{7'h00, 7'h43, 7'h45, 7'h46, 7'h07, 7'h06, 7'h41, 7'h67};
    sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    while (rcvd < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 8);
      if (sent < 8) begin in_data = sd[sent]; in_check = sc[sent]; end
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data)
          begin errors++; $display("FAIL b2b stable got v=%b d=%h exp v=1 d=%h", out_valid, out_data, prev_data); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== sd[rcvd] || out_ce !== 1'b0 || out_ue !== 1'b0)
          begin errors++; $display("FAIL b2b word%0d got %h ce=%b ue=%b exp %h ce=0 ue=0",
                                   rcvd, out_data, out_ce, out_ue, sd[rcvd]); end
        rcvd++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      cyc++;
    end
    #1; in_valid = 1'b0;
    checks++;
    if (rcvd !== 8) begin errors++; $display("FAIL b2b received got %0d exp 8", rcvd); end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b duplicate got out_valid %b exp 0", out_valid); end
  endtask

  task automatic test_reset_midstream;
    run_word("pre_rst", 32'h0, 7'h43, 32'h1, 1'b1, 1'b0, 7'h43);
    check_counts("pre_rst", 16'd2, 16'd0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1; in_check = 7'h43;
    @(posedge clk); #1;
    in_data = 32'h2; in_check = 7'h45;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      begin errors++; $display("FAIL fill got out_valid=%b in_ready=%b exp 1/0", out_valid, in_ready); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0)
      begin errors++; $display("FAIL mid_rst out got v=%b d=%h exp v=0 d=0", out_valid, out_data); end
    check_counts("mid_rst", 16'd0, 16'd0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL post_rst got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst dropped got out_valid %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_single_data;
    test_check_bits;
    test_double;
    test_triple_and_clear;
    test_high_bit;
    test_back_to_back;
    test_reset_midstream;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
